turbo_frame_sequencer: RTL and testbench
========================================

// Module: turbo_frame_sequencer
// PURPOSE
//  Sequences the turbo Decorder core. Buffers one frame of WORDS input words from an upstream
//  valid/ready stream, replays the frame to the core as WORDS back-to-back i_start cycles, then
//  waits for done. The core's result goes out on a valid/ready port.
//  A watchdog abandons frames the core never finishes. Sits between the frame source and the decoder core.
// PARAMETERS
//  DATA_W   84    width of one decoder input word (core i_data)
//  OUT_W    5     width of decoder result (core o_data)
//  WORDS    4     input words per frame, >=1
//  TIMEOUT  1023  max cycles in WAIT before the frame is abandoned, >=1
//  CNT_W    16    width of the frame and timeout counters
// PORTS
//  i_clk        in   1       clock, all logic on rising edge
//  i_rst_n      in   1       asynchronous active-low reset
//  i_abort      in   1       sync abort: drop the current frame and return to LOAD
//  i_in_valid   in   1       upstream word valid
//  o_in_ready   out  1       sequencer accepts a word this cycle
//  i_in_data    in   DATA_W  upstream word
//  o_dec_start  out  1       core i_start
//  o_dec_data   out  DATA_W  core i_data
//  i_dec_done   in   1       core done
//  i_dec_data   in   OUT_W   core o_data, sampled when i_dec_done=1
//  o_out_valid  out  1       result valid
//  i_out_ready  in   1       downstream accepts the result
//  o_out_data   out  OUT_W   captured result
//  o_timeout    out  1       1-cycle pulse when the watchdog expires
//  o_busy       out  1       state != LOAD
//  o_frame_cnt  out  CNT_W   frames completed with done; saturates at all-ones
//  o_tmo_cnt    out  CNT_W   frames abandoned by timeout; saturates at all-ones
// BEHAVIOUR
//  - Reset: state=LOAD, wr_idx=rd_idx=timer=0. o_dec_start, o_out_valid, o_timeout, counters=0.
//    o_dec_data=0, o_out_data=0. The frame buffer is not reset.
//  - o_in_ready=(state==LOAD). o_busy=(state!=LOAD). Both decode from the state register.
//  - LOAD: each valid&ready handshake writes buf[wr_idx] and increments wr_idx.
//    On the WORDS-th accept: wr_idx<=0, rd_idx<=0, go to FEED.
//  - FEED: o_dec_start=1 and o_dec_data=buf[rd_idx] for exactly WORDS consecutive cycles, no gaps.
//    The first FEED cycle is the cycle after the last accept. After the rd_idx=WORDS-1 cycle,
//    go to WAIT with timer=0. In all other states o_dec_start=0 and o_dec_data=0.
//  - WAIT: timer increments each cycle.
//    * i_dec_done=1: o_out_data<=i_dec_data, o_frame_cnt++, go to OUT. o_out_valid=1 the next cycle.
//    * timer==TIMEOUT-1 with no done: o_timeout pulses 1 cycle, o_tmo_cnt++, go to LOAD, no output.
//    * done and the timeout in the same cycle: done wins and there is no timeout pulse.
//  - OUT: o_out_valid=1 and o_out_data stable until i_out_ready=1, then go to LOAD the next cycle.
//    No new words are accepted while in OUT.
//  - i_dec_done outside WAIT is ignored: no capture, no count.
//  - i_abort (any state, priority over everything): go to LOAD, clear wr_idx/rd_idx/timer,
//    clear o_dec_start and o_out_valid. Counters are unchanged and there is no timeout pulse.
//    A partially loaded frame is discarded.
//  - Counters saturate; there is no wrap. Reset mid-frame returns to the reset state immediately (async).
//  - Latency: last accept at cycle N gives start at N+1..N+WORDS. Done at cycle M gives valid at M+1.
// TESTING
//  1 Four words A,B,C,D with valid every cycle -> ready drops after D; start high 4 cycles with
//    A,B,C,D in order; done with 5'h13 -> out_valid=1, out_data=5'h13 next cycle, frame_cnt=1.
//  2 Upstream gaps (valid toggling) -> start still high 4 consecutive cycles, data in order.
//  3 No done, TIMEOUT=8 -> timeout pulse 8 cycles after WAIT entry, tmo_cnt=1, ready=1, out_valid
//    never asserts.
//  4 Done on the timeout cycle -> result captured, no timeout pulse, frame_cnt++, tmo_cnt unchanged.
//  5 out_ready low for 5 cycles -> out_valid/out_data held 5 cycles, in_ready=0, spurious done
//    ignored, release -> LOAD.
//  6 Abort after 2 words loaded, then reset asserted during FEED -> start=0 at once, next frame of
//    4 fresh words decodes correctly, counters as expected.

Source files
------------

// File: rtl/turbo_frame_sequencer.sv
// rtl/turbo_frame_sequencer.sv - buffers one frame, replays it to the turbo decoder core, returns the result
module turbo_frame_sequencer #(
  parameter int DATA_W  = 84,
  parameter int OUT_W   = 5,
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_abort,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_dec_start,
  output logic [DATA_W-1:0] o_dec_data,
  input  logic              i_dec_done,
  input  logic [OUT_W-1:0]  i_dec_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [OUT_W-1:0]  o_out_data,
  output logic              o_timeout,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic [CNT_W-1:0]  o_tmo_cnt
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FEED,
    ST_WAIT,
    ST_OUT
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   wr_idx_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic [CNT_W-1:0]   timer_q;
  logic               dec_start_q;
  logic [DATA_W-1:0]  dec_data_q;
  logic               out_valid_q;
  logic [OUT_W-1:0]   out_data_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [CNT_W-1:0]   tmo_cnt_q;
  logic [DATA_W-1:0]  frame_buf_q [WORDS];

  logic               in_fire;
  logic [DATA_W-1:0]  first_word_d;
  logic [IDX_W-1:0]   rd_next_d;

  assign in_fire = (state_q == ST_LOAD) && i_in_valid && !i_abort;
  assign rd_next_d = rd_idx_q + 1'b1;

  // With a single-word frame the first word to replay is the one being accepted right now,
  // so it has to bypass the buffer.
  always_comb begin
    first_word_d = frame_buf_q[0];
    if (wr_idx_q == '0) begin
      first_word_d = i_in_data;
    end
  end

  // Frame storage; deliberately not reset, only the indices define what is valid.
  always_ff @(posedge i_clk) begin
    if (in_fire) begin
      frame_buf_q[wr_idx_q] <= i_in_data;
    end
  end

  // Sequencer FSM with all core- and result-facing outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      timer_q     <= '0;
      dec_start_q <= 1'b0;
      dec_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (i_abort) begin
        state_q     <= ST_LOAD;
        wr_idx_q    <= '0;
        rd_idx_q    <= '0;
        timer_q     <= '0;
        dec_start_q <= 1'b0;
        dec_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (i_in_valid) begin
              if (wr_idx_q == LAST_IDX) begin
                wr_idx_q    <= '0;
                rd_idx_q    <= '0;
                dec_start_q <= 1'b1;
                dec_data_q  <= first_word_d;
                state_q     <= ST_FEED;
              end else begin
                wr_idx_q <= wr_idx_q + 1'b1;
              end
            end
          end
          ST_FEED: begin
            // rd_idx_q names the word currently on o_dec_data; preload the next one.
            if (rd_idx_q == LAST_IDX) begin
              rd_idx_q    <= '0;
              dec_start_q <= 1'b0;
              dec_data_q  <= '0;
              timer_q     <= '0;
              state_q     <= ST_WAIT;
            end else begin
              rd_idx_q   <= rd_next_d;
              dec_data_q <= frame_buf_q[rd_next_d];
            end
          end
          ST_WAIT: begin
            // Done is checked first so a result on the last allowed cycle still counts.
            if (i_dec_done) begin
              out_data_q  <= i_dec_data;
              out_valid_q <= 1'b1;
              if (frame_cnt_q != CNT_MAX) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
              end
              state_q <= ST_OUT;
            end else if (timer_q == TMO_LAST) begin
              timeout_q <= 1'b1;
              if (tmo_cnt_q != CNT_MAX) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
              end
              timer_q <= '0;
              state_q <= ST_LOAD;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ST_OUT: begin
            if (i_out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= ST_LOAD;
            end
          end
          default: begin
            state_q <= ST_LOAD;
          end
        endcase
      end
    end
  end

  assign o_in_ready  = (state_q == ST_LOAD);
  assign o_busy      = (state_q != ST_LOAD);
  assign o_dec_start = dec_start_q;
  assign o_dec_data  = dec_data_q;
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;
  assign o_timeout   = timeout_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_tmo_cnt   = tmo_cnt_q;

endmodule

// File: tb/tb_turbo_frame_sequencer.sv
// tb/tb_turbo_frame_sequencer.sv - scoreboard bench for turbo_frame_sequencer
module tb_turbo_frame_sequencer;

  localparam int DATA_W  = 84;
  localparam int OUT_W   = 5;
  localparam int WORDS   = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_abort = 1'b0;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_in_data = '0;
  logic              o_dec_start;
  logic [DATA_W-1:0] o_dec_data;
  logic              i_dec_done = 1'b0;
  logic [OUT_W-1:0]  i_dec_data = '0;
  logic              o_out_valid;
  logic              i_out_ready = 1'b1;
  logic [OUT_W-1:0]  o_out_data;
  logic              o_timeout;
  logic              o_busy;
  logic [CNT_W-1:0]  o_frame_cnt;
  logic [CNT_W-1:0]  o_tmo_cnt;

  turbo_frame_sequencer #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .WORDS(WORDS), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_abort(i_abort),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_dec_start(o_dec_start), .o_dec_data(o_dec_data),
    .i_dec_done(i_dec_done), .i_dec_data(i_dec_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_timeout(o_timeout), .o_busy(o_busy),
    .o_frame_cnt(o_frame_cnt), .o_tmo_cnt(o_tmo_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_feed[$];
  logic [OUT_W-1:0]  exp_out[$];
  int exp_tmo = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mkw(input int k);
    return DATA_W'({k, 32'hDEAD0000 ^ k, k * 3 + 1});
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Core-facing monitor: every start cycle must carry the next expected word.
  always @(negedge i_clk) begin
    if (i_rst_n && o_dec_start) begin
      if (exp_feed.size() == 0) begin
        chk("feed_unexpected_start", 1, 0);
      end else begin
        chk("feed_data", o_dec_data, exp_feed.pop_front());
      end
    end
  end

  // Result monitor: compare on each downstream handshake.
  always @(negedge i_clk) begin
    if (i_rst_n && o_out_valid && i_out_ready) begin
      if (exp_out.size() == 0) begin
        chk("out_unexpected", 1, 0);
      end else begin
        chk("out_data", o_out_data, exp_out.pop_front());
      end
    end
  end

  // Watchdog pulse monitor.
  always @(negedge i_clk) begin
    if (i_rst_n && o_timeout) begin
      chk("timeout_expected", (exp_tmo > 0), 1);
      if (exp_tmo > 0) exp_tmo--;
    end
  end

  task automatic send_word(input logic [DATA_W-1:0] d);
    int n;
    i_in_valid = 1'b1;
    i_in_data  = d;
    n = 0;
    while (!o_in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_ready_timeout", 0, 1);
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int i = 0; i < WORDS; i++) exp_feed.push_back(mkw(base + i));
    for (int i = 0; i < WORDS; i++) begin
      send_word(mkw(base + i));
      if (gaps && i < WORDS - 1) begin
        step();
        step();
      end
    end
  endtask

  // Called on the first FEED cycle: start must be high for WORDS cycles, then drop.
  task automatic check_feed(input string nm);
    chk({nm, "_ready_low"}, o_in_ready, 0);
    for (int i = 0; i < WORDS; i++) begin
      chk({nm, "_start_high"}, o_dec_start, 1);
      step();
    end
    chk({nm, "_start_low"}, o_dec_start, 0);
    chk({nm, "_busy_wait"}, o_busy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_dec_start, 0);
    chk("rst_dec_data", o_dec_data, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    chk("rst_tmo_cnt", o_tmo_cnt, 0);
    i_rst_n = 1'b1;
    step();

    // 1: back-to-back words, immediate done
    send_frame(16, 1'b0);
    check_feed("t1");
    i_dec_done = 1'b1;
    i_dec_data = 5'h13;
    exp_out.push_back(5'h13);
    step();
    i_dec_done = 1'b0;
    chk("t1_out_valid", o_out_valid, 1);
    chk("t1_out_data", o_out_data, 5'h13);
    chk("t1_frame_cnt", o_frame_cnt, 1);
    step();
    chk("t1_back_to_load", o_in_ready, 1);
    chk("t1_out_valid_low", o_out_valid, 0);

    // 2: upstream gaps, done a few cycles into WAIT
    send_frame(32, 1'b1);
    check_feed("t2");
    step();
    step();
    i_dec_done = 1'b1;
    i_dec_data = 5'h0A;
    exp_out.push_back(5'h0A);
    step();
    i_dec_done = 1'b0;
    chk("t2_out_valid", o_out_valid, 1);
    chk("t2_frame_cnt", o_frame_cnt, 2);
    step();

    // 3: watchdog expiry
    send_frame(48, 1'b0);
    check_feed("t3");
    exp_tmo++;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step();
      chk("t3_no_early_timeout", o_timeout, 0);
    end
    step();
    chk("t3_timeout_pulse", o_timeout, 1);
    chk("t3_tmo_cnt", o_tmo_cnt, 1);
    chk("t3_in_ready", o_in_ready, 1);
    chk("t3_out_valid", o_out_valid, 0);
    chk("t3_frame_cnt", o_frame_cnt, 2);
    step();
    chk("t3_pulse_one_cycle", o_timeout, 0);

    // 4: done on the timeout cycle
    send_frame(64, 1'b0);
    check_feed("t4");
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    i_dec_done = 1'b1;
    i_dec_data = 5'h1F;
    exp_out.push_back(5'h1F);
    step();
    i_dec_done = 1'b0;
    chk("t4_no_timeout", o_timeout, 0);
    chk("t4_out_valid", o_out_valid, 1);
    chk("t4_frame_cnt", o_frame_cnt, 3);
    chk("t4_tmo_cnt", o_tmo_cnt, 1);
    step();

    // 5: downstream backpressure, spurious done and upstream words ignored in OUT
    send_frame(80, 1'b0);
    check_feed("t5");
    i_out_ready = 1'b0;
    i_dec_done  = 1'b1;
    i_dec_data  = 5'h05;
    exp_out.push_back(5'h05);
    step();
    i_dec_data = 5'h1A;
    i_in_valid = 1'b1;
    i_in_data  = mkw(999);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", o_out_valid, 1);
      chk("t5_hold_data", o_out_data, 5'h05);
      chk("t5_in_ready_low", o_in_ready, 0);
      step();
    end
    i_dec_done  = 1'b0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    step();
    chk("t5_back_to_load", o_in_ready, 1);
    chk("t5_out_valid_low", o_out_valid, 0);
    chk("t5_frame_cnt", o_frame_cnt, 4);

    // 6: abort partial frame, then reset during FEED, then a clean frame
    send_word(mkw(500));
    send_word(mkw(501));
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("t6_abort_ready", o_in_ready, 1);
    chk("t6_abort_busy", o_busy, 0);
    chk("t6_abort_frame_cnt", o_frame_cnt, 4);
    chk("t6_abort_tmo_cnt", o_tmo_cnt, 1);
    send_frame(96, 1'b0);
    chk("t6_feed_start", o_dec_start, 1);
    step();
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_start", o_dec_start, 0);
    chk("t6_rst_dec_data", o_dec_data, 0);
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_frame_cnt", o_frame_cnt, 0);
    chk("t6_rst_tmo_cnt", o_tmo_cnt, 0);
    exp_feed.delete();
    step();
    i_rst_n = 1'b1;
    step();
    send_frame(112, 1'b0);
    check_feed("t6");
    i_dec_done = 1'b1;
    i_dec_data = 5'h07;
    exp_out.push_back(5'h07);
    step();
    i_dec_done = 1'b0;
    chk("t6_out_data", o_out_data, 5'h07);
    chk("t6_frame_cnt", o_frame_cnt, 1);
    chk("t6_tmo_cnt", o_tmo_cnt, 0);
    step();
    step();

    chk("end_feed_queue_empty", exp_feed.size(), 0);
    chk("end_out_queue_empty", exp_out.size(), 0);
    chk("end_tmo_pending", exp_tmo, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
